sump_cmd_assembler: RTL and testbench

//  Sequences the byte stream from the UART receiver into complete SUMP commands.

---
 rtl/sump_cmd_assembler.sv | 140 ++++++++++++++
 tb/tb_sump_cmd_assembler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sump_cmd_assembler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sump_cmd_assembler
// Assembles the UART receive byte stream into complete SUMP commands.
// A short command is one opcode byte with bit7 = 0. A long command is an
// opcode byte with bit7 = 1 followed by four payload bytes, little-endian.
// If the gap between bytes of a long command grows too large, the partial
// command is dropped. A finished command is held until the consumer takes it.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous reset, active high
//   rx_data_i      received byte
//   rx_valid_i     single-cycle strobe qualifying rx_data_i
//   cmd_o          assembled opcode
//   data_o         long-command payload {b4,b3,b2,b1}; 0 for short commands
//   cmd_long_o     cmd_o/data_o hold a long command
//   cmd_valid_o    command available, held until accepted
//   cmd_ready_i    consumer accepts when cmd_valid_o && cmd_ready_i
//   busy_o         assembler is not idle
//   err_timeout_o  one-cycle pulse: long command dropped on inter-byte timeout
//   err_overrun_o  one-cycle pulse: byte dropped while a command was pending
//
// state   | meaning
// IDLE    | waiting for an opcode byte
// COLLECT | long opcode seen, gathering the four payload bytes
// PENDING | command presented on the outputs, waiting for the handshake
// ---------------------------------------------------------------------------
module sump_cmd_assembler #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  cmd_o,
    output logic [31:0] data_o,
    output logic        cmd_long_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic        busy_o,
    output logic        err_timeout_o,
    output logic        err_overrun_o
);

    // A disabled timeout still needs a one-bit timer to keep the widths legal.
    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TMR_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMR_LAST_INT);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       idx;
    logic [TMR_W-1:0] timer;
    logic             accept;
    logic             start;

    assign accept = (state == PENDING) && cmd_ready_i;
    // A byte landing on the handshake cycle starts the next command directly,
    // so ready held high sustains one short command per clock.
    assign start  = rx_valid_i && ((state == IDLE) || accept);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            idx           <= 2'd0;
            timer         <= '0;
            cmd_o         <= 8'h00;
            data_o        <= 32'h0;
            cmd_long_o    <= 1'b0;
            cmd_valid_o   <= 1'b0;
            busy_o        <= 1'b0;
            err_timeout_o <= 1'b0;
            err_overrun_o <= 1'b0;
        end else begin
            err_timeout_o <= 1'b0;
            err_overrun_o <= 1'b0;

            case (state)
                COLLECT: begin
                    // An arriving byte takes priority over an expiring timer.
                    if (rx_valid_i) begin
                        data_o[{idx, 3'b000} +: 8] <= rx_data_i;
                        timer <= '0;
                        if (idx == 2'd3) begin
                            state       <= PENDING;
                            cmd_valid_o <= 1'b1;
                            cmd_long_o  <= 1'b1;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else if (TIMEOUT_EN && (timer == TMR_LAST)) begin
                        state         <= IDLE;
                        busy_o        <= 1'b0;
                        idx           <= 2'd0;
                        timer         <= '0;
                        data_o        <= 32'h0;
                        err_timeout_o <= 1'b1;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                PENDING: begin
                    if (accept) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        cmd_valid_o <= 1'b0;
                    end else if (rx_valid_i) begin
                        err_overrun_o <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Opcode capture; overrides the handshake return to IDLE above.
            if (start) begin
                cmd_o      <= rx_data_i;
                data_o     <= 32'h0;
                cmd_long_o <= 1'b0;
                idx        <= 2'd0;
                timer      <= '0;
                busy_o     <= 1'b1;
                if (rx_data_i[7]) begin
                    state       <= COLLECT;
                    cmd_valid_o <= 1'b0;
                end else begin
                    state       <= PENDING;
                    cmd_valid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sump_cmd_assembler.sv
`timescale 1ns/1ps
module tb_sump_cmd_assembler;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  cmd;
    logic [31:0] data;
    logic        cmd_long;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        busy;
    logic        err_timeout;
    logic        err_overrun;

    always #5 clk = ~clk;

    sump_cmd_assembler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .cmd_o         (cmd),
        .data_o        (data),
        .cmd_long_o    (cmd_long),
        .cmd_valid_o   (cmd_valid),
        .cmd_ready_i   (cmd_ready),
        .busy_o        (busy),
        .err_timeout_o (err_timeout),
        .err_overrun_o (err_overrun)
    );

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] payload;
        logic        lng;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 0;

    // Reference model: a command is either being collected (list of payload
    // bytes so far) or waiting to be taken; errors are flagged per clock.
    bit         m_pend, m_coll, m_to, m_ov;
    cmd_t       m_cmd;
    logic [7:0] m_op;
    logic [7:0] m_bytes[$];
    int         m_idle;

    // Expectations for the outputs after the most recent clock edge.
    bit e_valid, e_busy, e_to, e_ov;

    task automatic model_clear();
        m_pend = 0; m_coll = 0; m_to = 0; m_ov = 0; m_idle = 0;
        m_bytes.delete();
        exp_q.delete();
        e_valid = 0; e_busy = 0; e_to = 0; e_ov = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit r);
        bit free;
        m_to = 0;
        m_ov = 0;
        free = !m_pend;
        if (m_pend && r) begin
            exp_q.push_back(m_cmd);
            m_pend = 0;
            free = 1;
        end
        if (v) begin
            if (m_coll) begin
                m_bytes.push_back(b);
                m_idle = 0;
                if (m_bytes.size() == 4) begin
                    m_coll = 0;
                    m_pend = 1;
                    m_cmd.op      = m_op;
                    m_cmd.payload = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_cmd.lng     = 1'b1;
                end
            end else if (free) begin
                if (b[7]) begin
                    m_coll = 1;
                    m_op   = b;
                    m_bytes.delete();
                    m_idle = 0;
                end else begin
                    m_pend = 1;
                    m_cmd.op      = b;
                    m_cmd.payload = 32'h0;
                    m_cmd.lng     = 1'b0;
                end
            end else begin
                m_ov = 1;
            end
        end else if (m_coll) begin
            m_idle++;
            if (m_idle == TO) begin
                m_coll = 0;
                m_to   = 1;
            end
        end
    endtask

    // Called just after a rising edge: drives one clock worth of inputs.
    task automatic step(input bit v, input logic [7:0] b, input bit r);
        rx_valid  = v;
        rx_data   = b;
        cmd_ready = r;
        model_step(v, b, r);
        @(posedge clk);
        #1;
        e_valid = m_pend;
        e_busy  = m_pend || m_coll;
        e_to    = m_to;
        e_ov    = m_ov;
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if ({cmd, data, cmd_long, cmd_valid, busy, err_timeout, err_overrun} !== '0) begin
            n_fail++;
            $display("FAIL %s: cmd=%h data=%h long=%b valid=%b busy=%b to=%b ov=%b, want all 0",
                     name, cmd, data, cmd_long, cmd_valid, busy, err_timeout, err_overrun);
        end
    endtask

    task automatic reset_mid();
        rx_valid = 0;
        #2 rst = 1;
        #1 check_zero("async_reset");
        model_clear();
        @(posedge clk);
        #1 rst = 0;
    endtask

    // Monitor: per-cycle status and scoreboard pop on every handshake.
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            n_tests++;
            if ({cmd_valid, busy, err_timeout, err_overrun} !== {e_valid, e_busy, e_to, e_ov}) begin
                n_fail++;
                $display("FAIL status @%0t: valid/busy/to/ov got %b%b%b%b want %b%b%b%b", $time,
                         cmd_valid, busy, err_timeout, err_overrun, e_valid, e_busy, e_to, e_ov);
            end
            if (cmd_valid && cmd_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_cmd @%0t: got cmd=%h data=%h long=%b, want none",
                             $time, cmd, data, cmd_long);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({cmd, data, cmd_long} !== mon_e) begin
                        n_fail++;
                        $display("FAIL cmd @%0t: got cmd=%h data=%h long=%b want cmd=%h data=%h long=%b",
                                 $time, cmd, data, cmd_long, mon_e.op, mon_e.payload, mon_e.lng);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] seq[4];
        int gap;
        rst = 1; rx_valid = 0; rx_data = 8'h00; cmd_ready = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst = 0;
        chk_en = 1;

        // short command
        step(1, 8'h01, 1); step(0, 8'h00, 1); step(0, 8'h00, 1);

        // long command with 10-clock gaps
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        step(1, 8'hC0, 1);
        for (int i = 0; i < 4; i++) begin
            repeat (10) step(0, 8'h00, 1);
            step(1, seq[i], 1);
        end
        step(0, 8'h00, 1); step(0, 8'h00, 1);

        // timeout, then a short command recovers
        step(1, 8'h80, 1); step(1, 8'hAA, 1);
        repeat (TO) step(0, 8'h00, 1);
        step(1, 8'h00, 1); step(0, 8'h00, 1); step(0, 8'h00, 1);

        // byte arriving on the expiry cycle wins every time
        step(1, 8'h81, 1);
        for (int i = 0; i < 4; i++) begin
            repeat (TO - 1) step(0, 8'h00, 1);
            step(1, 8'($urandom), 1);
        end
        step(0, 8'h00, 1); step(0, 8'h00, 1);

        // backpressure with overrun
        step(1, 8'h02, 0); step(1, 8'h03, 0); step(0, 8'h00, 0);
        step(0, 8'h00, 1); step(0, 8'h00, 1);

        // handshake and new byte on the same clock
        step(1, 8'h02, 0); step(1, 8'h04, 1); step(0, 8'h00, 1); step(0, 8'h00, 1);

        // back-to-back short commands with ready held
        step(1, 8'h05, 1); step(1, 8'h06, 1); step(1, 8'h07, 1); step(0, 8'h00, 1); step(0, 8'h00, 1);

        // reset in the middle of a long command
        step(1, 8'h82, 1); step(1, 8'h01, 1);
        reset_mid();
        step(1, 8'h05, 1); step(0, 8'h00, 1); step(0, 8'h00, 1);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                gap = $urandom_range(TO - 5, TO + 5);
                for (int g = 0; g < gap; g++) step(0, 8'h00, $urandom_range(0, 3) != 0);
            end else begin
                step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
            end
        end

        repeat (TO + 10) step(0, 8'h00, 1);
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d commands never presented, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
